// File: rtl/twi_monitor_pkg.sv
// twi_monitor_pkg: bus state, frame layout and frame packing shared by the TWI capture logic
package twi_monitor_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} bus_state_t;
  localparam int FRAME_W  = 18;
  localparam int ADDR_MSB = 17;
  localparam int ADDR_LSB = 10;
  localparam int ADDR_ACK = 9;
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 1;
  localparam int DATA_ACK = 0;
  function automatic logic [FRAME_W-1:0] pack_frame(logic [7:0] a, logic a_ack, logic [7:0] d, logic d_ack);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[ADDR_MSB:ADDR_LSB] = a;
    f[ADDR_ACK]          = a_ack;
    f[DATA_MSB:DATA_LSB] = d;
    f[DATA_ACK]          = d_ack;
    return f;
  endfunction
endpackage

// File: rtl/twi_line_filter.sv
// twi_line_filter: 2-FF synchronizer followed by a stability filter; output only follows
// the line after FILTER_LEN consecutive identical samples.
module twi_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      o_line <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == o_line) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        o_line <= r_sync[1];
        r_cnt  <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/twi_frame_capture.sv
// twi_frame_capture: passive TWI sniffer assembling {addr, ack, data, ack} frames and
// presenting them through a level handshake with a one-deep pending buffer.
module twi_frame_capture
  import twi_monitor_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               scl_in,
  input  logic               sda_in,
  input  logic               TX_available,
  output logic [FRAME_W-1:0] frame,
  output logic               new_data_ready,
  output logic               overrun,
  output logic               bus_active
);
  bus_state_t         r_state, w_next;
  logic               w_scl, w_sda, r_scl_d, r_sda_d;
  logic               w_start, w_stop, w_shift_en, w_last, w_done, w_free;
  logic [7:0]         r_shift, r_addr;
  logic               r_addr_ack;
  logic [3:0]         r_cnt;
  logic [FRAME_W-1:0] r_pend, w_frame_new;
  logic               r_pend_v;

  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .rst_n(reset), .i_line(scl_in), .o_line(w_scl));
  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .rst_n(reset), .i_line(sda_in), .o_line(w_sda));

  assign w_start     = enable & w_scl & r_sda_d & ~w_sda;
  assign w_stop      = enable & w_scl & ~r_sda_d & w_sda;
  assign w_shift_en  = enable & w_scl & ~r_scl_d & (r_state != ST_IDLE) & ~w_start & ~w_stop;
  assign w_last      = r_cnt == 4'd8;
  assign w_free      = ~new_data_ready & TX_available;
  assign w_frame_new = pack_frame(r_addr, r_addr_ack, r_shift, w_sda);

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ST_IDLE;
    else r_state <= w_next;

  always_comb
    w_next = !enable ? ST_IDLE :
             w_start ? ST_ADDR :
             w_stop  ? ST_IDLE :
             (w_shift_en && w_last && r_state == ST_ADDR) ? ST_DATA : r_state;

  always_comb begin
    bus_active = r_state != ST_IDLE;
    w_done     = w_shift_en && w_last && r_state == ST_DATA;
  end

  // The 9th bit of a byte is the ACK: it is captured separately and never shifted in
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_addr_ack <= 1'b0;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      if (w_start) r_cnt <= '0;
      else if (w_shift_en) begin
        r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        if (!w_last) r_shift <= {r_shift[6:0], w_sda};
        if (w_last && r_state == ST_ADDR) begin
          r_addr     <= r_shift;
          r_addr_ack <= w_sda;
        end
      end
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      frame          <= '0;
      new_data_ready <= 1'b0;
      overrun        <= 1'b0;
      r_pend         <= '0;
      r_pend_v       <= 1'b0;
    end else begin
      if (new_data_ready && !TX_available) new_data_ready <= 1'b0;
      if (w_free) begin
        if (r_pend_v) begin
          frame          <= r_pend;
          new_data_ready <= 1'b1;
          r_pend_v       <= w_done;
          if (w_done) r_pend <= w_frame_new;
        end else if (w_done) begin
          frame          <= w_frame_new;
          new_data_ready <= 1'b1;
        end
      end else if (w_done) begin
        if (!r_pend_v) begin
          r_pend   <= w_frame_new;
          r_pend_v <= 1'b1;
        end else overrun <= 1'b1;
      end
    end
endmodule

// File: tb/tb_twi_frame_capture.sv
// tb_twi_frame_capture: directed TWI transactions against hand-computed frames and handshake timing
module tb_twi_frame_capture;
  localparam int H = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        scl_in = 1'b1;
  logic        sda_in = 1'b1;
  logic        TX_available = 1'b1;
  logic [17:0] frame;
  logic        new_data_ready, overrun, bus_active;
  int          n_cmp = 0;
  int          n_err = 0;

  twi_frame_capture #(.FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .scl_in(scl_in), .sda_in(sda_in),
    .TX_available(TX_available), .frame(frame), .new_data_ready(new_data_ready),
    .overrun(overrun), .bus_active(bus_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_in = 1'b1; wait_cyc(H);
    scl_in = 1'b1; wait_cyc(H);
    sda_in = 1'b0; wait_cyc(H);
    scl_in = 1'b0; wait_cyc(H);
  endtask

  task automatic i2c_stop();
    sda_in = 1'b0; wait_cyc(H);
    scl_in = 1'b1; wait_cyc(H);
    sda_in = 1'b1; wait_cyc(H);
  endtask

  task automatic i2c_bit(input logic b);
    sda_in = b;    wait_cyc(H);
    scl_in = 1'b1; wait_cyc(H);
    scl_in = 1'b0; wait_cyc(H);
  endtask

  task automatic i2c_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(ack);
  endtask

  task automatic consume();
    TX_available = 1'b0; wait_cyc(3);
    TX_available = 1'b1; wait_cyc(2);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_frame", 32'(frame), 0);
    check("rst_ndr", 32'(new_data_ready), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_bus", 32'(bus_active), 0);
    reset = 1'b1;
    wait_cyc(H);

    // write A0/ACK, 5A/ACK; last ACK bit driven by hand to time new_data_ready
    i2c_start();
    check("t1_bus", 32'(bus_active), 1);
    i2c_byte(8'hA0, 1'b0);
    for (int i = 7; i >= 0; i--) i2c_bit(8'h5A >> i);
    sda_in = 1'b0; wait_cyc(H);
    scl_in = 1'b1; wait_cyc(5);
    check("t1_ndr_early", 32'(new_data_ready), 0);
    wait_cyc(1);
    check("t1_ndr_lat", 32'(new_data_ready), 1);
    check("t1_frame", 32'(frame), 32'h280B4);
    wait_cyc(H - 6);
    scl_in = 1'b0; wait_cyc(H);
    i2c_stop();
    wait_cyc(H);
    check("t1_bus_off", 32'(bus_active), 0);
    check("t1_ndr_hold", 32'(new_data_ready), 1);
    TX_available = 1'b0; wait_cyc(1);
    check("t1_ndr_clr", 32'(new_data_ready), 0);
    check("t1_frame_keep", 32'(frame), 32'h280B4);
    TX_available = 1'b1; wait_cyc(2);

    // data NACK
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h5A, 1'b1);
    check("t2_frame", 32'(frame), 32'h280B5);
    check("t2_ndr", 32'(new_data_ready), 1);
    i2c_stop();
    consume();

    // second frame parked in pending while presenter busy
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h11, 1'b0);
    check("t3_frame1", 32'(frame), 32'h28022);
    check("t3_ndr1", 32'(new_data_ready), 1);
    TX_available = 1'b0;
    i2c_byte(8'h22, 1'b0);
    check("t3_ndr_busy", 32'(new_data_ready), 0);
    check("t3_frame_hold", 32'(frame), 32'h28022);
    TX_available = 1'b1; wait_cyc(1);
    check("t3_ndr2", 32'(new_data_ready), 1);
    check("t3_frame2", 32'(frame), 32'h28044);
    check("t3_ovr", 32'(overrun), 0);
    i2c_stop();
    consume();

    // three frames, only two buffers: third dropped
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h01, 1'b0);
    check("t4_frame1", 32'(frame), 32'h28002);
    TX_available = 1'b0; wait_cyc(3);
    check("t4_ndr_clr", 32'(new_data_ready), 0);
    i2c_byte(8'h02, 1'b0);
    check("t4_ovr0", 32'(overrun), 0);
    i2c_byte(8'h03, 1'b0);
    check("t4_ovr1", 32'(overrun), 1);
    check("t4_frame_hold", 32'(frame), 32'h28002);
    TX_available = 1'b1; wait_cyc(1);
    check("t4_ndr2", 32'(new_data_ready), 1);
    check("t4_frame2", 32'(frame), 32'h28004);
    i2c_stop();
    consume();
    check("t4_no_third", 32'(new_data_ready), 0);
    check("t4_frame_last", 32'(frame), 32'h28004);
    check("t4_ovr_sticky", 32'(overrun), 1);

    // partial address then STOP, then a short SDA glitch with SCL high
    i2c_start();
    for (int i = 0; i < 5; i++) i2c_bit(1'b1);
    i2c_stop();
    check("t5_bus_stop", 32'(bus_active), 0);
    sda_in = 1'b0; wait_cyc(2);
    sda_in = 1'b1; wait_cyc(H);
    check("t5_bus_glitch", 32'(bus_active), 0);
    check("t5_ndr", 32'(new_data_ready), 0);
    check("t5_frame", 32'(frame), 32'h28004);

    // reset mid-frame after 12 bits
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1);
    check("t6_bus_pre", 32'(bus_active), 1);
    reset = 1'b0; #1;
    check("t6_frame", 32'(frame), 0);
    check("t6_ndr", 32'(new_data_ready), 0);
    check("t6_ovr", 32'(overrun), 0);
    check("t6_bus", 32'(bus_active), 0);
    scl_in = 1'b1; sda_in = 1'b1;
    wait_cyc(H);
    reset = 1'b1;
    wait_cyc(H);
    check("t6_bus_idle", 32'(bus_active), 0);
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h3C, 1'b0);
    check("t6_frame_new", 32'(frame), 32'h28078);
    check("t6_ndr_new", 32'(new_data_ready), 1);
    i2c_stop();
    wait_cyc(H);
    check("t6_bus_end", 32'(bus_active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/twi_frame_capture.md
# twi_frame_capture

Passive I2C/TWI bus sniffer that sits directly upstream of the frame presenter. It samples the raw SCL/SDA lines and detects START, repeated START and STOP. Each address byte plus one data byte, with both ACK bits, is assembled into an 18-bit frame and handed downstream with a level handshake. A one-deep pending buffer absorbs a frame that completes while the presenter is still transmitting the previous one.

## Interface
Parameters:
- FILTER_LEN, default 3: number of consecutive identical synchronized samples needed before a line level is accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  bus capture enable
- scl_in  in  1  raw SCL line, asynchronous
- sda_in  in  1  raw SDA line, asynchronous
- TX_available  in  1  presenter idle; frame may be replaced
- frame  out  18  {addr[7:0], addr_ack, data[7:0], data_ack}
- new_data_ready  out  1  frame valid; held until consumed
- overrun  out  1  sticky flag: a frame was dropped
- bus_active  out  1  high between START and STOP

## Operation
- Line conditioning: each line passes through a 2-FF synchronizer, then the FILTER_LEN stability filter. Filtered values power up and reset to 1.
- Bus events use the filtered lines:
  - START/Sr: SDA 1→0 while SCL=1.
  - STOP: SDA 0→1 while SCL=1.
  - Bit sample: SCL 0→1. SDA is taken from the filtered value in that same cycle.
- Bus FSM states: IDLE, ADDR, DATA.
  - IDLE: START → ADDR, bit_cnt=0.
  - ADDR: shift a bit into the address shift register on each SCL rise. At bit_cnt=8 (9th bit = ACK), latch addr_reg and addr_ack, then → DATA with bit_cnt=0.
  - DATA: shift bits. On the 9th bit, a frame is complete. Stay in DATA with bit_cnt=0, so each further data byte yields a new frame that reuses addr_reg.
  - START in any state → ADDR, bit_cnt=0; any partial byte is discarded.
  - STOP in any state → IDLE; any partial byte is discarded, with no frame and no flag.
  - START and STOP cannot be detected in the same cycle, since both require an SDA edge.
- enable=0 forces the bus FSM to IDLE and ignores bus events. The output handshake and the pending buffer keep running.
- Output handshake:
  - Frame completes, output is free (new_data_ready=0 and TX_available=1): load frame and set new_data_ready the next cycle.
  - Frame completes, output is busy, pending buffer empty: store the frame in pending.
  - Frame completes, output busy and pending full: drop the new frame and set overrun=1. overrun clears only on reset.
  - new_data_ready clears on the first cycle TX_available=0 while new_data_ready=1 (presenter has left idle).
  - frame must not change while new_data_ready=1 or TX_available=0.
  - When the output becomes free and pending is full: move pending to frame, set new_data_ready, clear pending. If a frame completes in the same cycle, it enters pending.
- Reset values: frame=0, new_data_ready=0, overrun=0, bus_active=0, FSM=IDLE, pending empty.

## Timing
- Event latency: 2 (synchronizer) + FILTER_LEN cycles from the raw pin edge to the filtered edge. The event is acted on in the cycle the filtered edge is seen.
- new_data_ready rises 1 cycle after the cycle in which the 9th data-byte bit is sampled, if the output is free.
- Pending release: new_data_ready rises 1 cycle after TX_available returns high.
- Reset asserted mid-frame: all state clears immediately and asynchronously. After release, capture resumes only at the next START.
- The design requires an SCL high/low time of at least FILTER_LEN+2 clk periods.

## Structure
- twi_monitor_pkg:
  - bus state enum.
  - FRAME_W=18.
  - Field positions ADDR_MSB=17, ADDR_LSB=10, ADDR_ACK=9, DATA_MSB=8, DATA_LSB=1, DATA_ACK=0.
- Sub-module twi_line_filter (synchronizer + stability counter, parameter FILTER_LEN), instantiated once for SCL and once for SDA.
- The top level holds the bus FSM, shift register, bit counter, pending buffer and handshake.

## Test plan
- Write 0xA0 ACK, data 0x5A ACK, STOP, with TX_available=1 → frame=18'h280B4 and new_data_ready=1 until TX_available drops.
- Same transaction with a data NACK → frame=18'h280B5.
- 0xA0, 0x11, 0x22 in one transaction, with TX_available held low from the first frame's handshake until after the second byte → frames 18'h28022 then 18'h28044. The second is released 1 cycle after TX_available returns high; overrun=0.
- Three frames complete while TX_available=0 → the first two are delivered in order, the third is dropped, and overrun=1 stays set.
- STOP after 5 address bits, then a 2-cycle SDA glitch while SCL is high (FILTER_LEN=3) → no frame, bus_active=0.
- Reset pulsed after 12 bits of a frame → all outputs return to reset values immediately. The next full transaction captures correctly.
